// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares a single-port data memory between two requesters (0: pipeline MEM
// stage, 1: loader/debug/DMA) with round-robin fairness. Every access runs as
// a fixed IDLE -> SERVE -> ACK sequence, and addresses are range/alignment
// checked before they are allowed to reach the memory.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   rN_read/rN_write (N=0,1)  level request, held until rN_ack
//   rN_addr, rN_wdata         byte address and write data
//   rN_ack, rN_err            one-cycle completion pulse, rejected-access flag
//   rN_rdata                  read data, held until the next ack to N
//   mem_read/mem_write        memory strobes (high only in SERVE)
//   mem_address, mem_data     memory address and write data
//   mem_result                memory read data
//   busy                      high in SERVE and ACK
//   cnt0, cnt1                saturating per-requester ack counters
module mem_port_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'd1024,
  parameter int unsigned MEM_WORDS = 65536,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_read,
  input  logic             r0_write,
  input  logic [31:0]      r0_addr,
  input  logic [31:0]      r0_wdata,
  output logic             r0_ack,
  output logic             r0_err,
  output logic [31:0]      r0_rdata,
  input  logic             r1_read,
  input  logic             r1_write,
  input  logic [31:0]      r1_addr,
  input  logic [31:0]      r1_wdata,
  output logic             r1_ack,
  output logic             r1_err,
  output logic [31:0]      r1_rdata,
  output logic             mem_read,
  output logic             mem_write,
  output logic [31:0]      mem_address,
  output logic [31:0]      mem_data,
  input  logic [31:0]      mem_result,
  output logic             busy,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  // Byte address of the last valid word; one extra bit so the sum cannot wrap.
  localparam logic [32:0] LAST_ADDR =
    {1'b0, BASE_ADDR} + 33'(4 * MEM_WORDS) - 33'd4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    ACK   = 2'd2
  } state_e;

  state_e             state_q;
  logic               last_grant_q;
  logic               id_q;
  logic               err_q;
  logic               write_q;
  logic               mem_read_q;
  logic               mem_write_q;
  logic [31:0]        mem_address_q;
  logic [31:0]        mem_data_q;
  logic               r0_ack_q, r1_ack_q;
  logic               r0_err_q, r1_err_q;
  logic [31:0]        r0_rdata_q, r1_rdata_q;
  logic [CNT_W-1:0]   cnt0_q, cnt1_q;

  // Arbitration and checking of the request that would be granted this cycle.
  logic               req0_d, req1_d;
  logic               gid_d;
  logic               sel_read_d, sel_write_d, sel_err_d;
  logic [31:0]        sel_addr_d, sel_wdata_d;

  // NOTE: every signal gets a value on every path through this block, so no
  // latch is inferred; an if without an else here would create one.
  always_comb begin
    req0_d = r0_read | r0_write;
    req1_d = r1_read | r1_write;
    // On a tie the requester that did not win last time goes first.
    if (req0_d && req1_d) gid_d = ~last_grant_q;
    else                  gid_d = req1_d;
    sel_read_d  = gid_d ? r1_read  : r0_read;
    sel_write_d = gid_d ? r1_write : r0_write;
    sel_addr_d  = gid_d ? r1_addr  : r0_addr;
    sel_wdata_d = gid_d ? r1_wdata : r0_wdata;
    sel_err_d   = (sel_read_d & sel_write_d)
                | (sel_addr_d[1:0] != 2'b00)
                | (sel_addr_d < BASE_ADDR)
                | ({1'b0, sel_addr_d} > LAST_ADDR);
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      id_q          <= 1'b0;
      err_q         <= 1'b0;
      write_q       <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
      r0_ack_q      <= 1'b0;
      r1_ack_q      <= 1'b0;
      r0_err_q      <= 1'b0;
      r1_err_q      <= 1'b0;
      r0_rdata_q    <= '0;
      r1_rdata_q    <= '0;
      cnt0_q        <= '0;
      cnt1_q        <= '0;
    end else begin
      // Ack and err are single-cycle pulses.
      r0_ack_q <= 1'b0;
      r1_ack_q <= 1'b0;
      r0_err_q <= 1'b0;
      r1_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req0_d || req1_d) begin
            state_q       <= SERVE;
            id_q          <= gid_d;
            last_grant_q  <= gid_d;
            err_q         <= sel_err_d;
            write_q       <= sel_write_d;
            // A rejected access never drives the memory pins.
            mem_read_q    <= ~sel_err_d & sel_read_d;
            mem_write_q   <= ~sel_err_d & sel_write_d;
            mem_address_q <= sel_err_d ? '0 : sel_addr_d;
            mem_data_q    <= (~sel_err_d & sel_write_d) ? sel_wdata_d : '0;
          end
        end
        SERVE: begin
          state_q       <= ACK;
          mem_read_q    <= 1'b0;
          mem_write_q   <= 1'b0;
          mem_address_q <= '0;
          mem_data_q    <= '0;
          // Reads capture the memory result; rejected accesses return zero;
          // good writes leave the held read data alone.
          if (err_q || !write_q) begin
            if (id_q) r1_rdata_q <= err_q ? '0 : mem_result;
            else      r0_rdata_q <= err_q ? '0 : mem_result;
          end
          if (id_q) begin
            r1_ack_q <= 1'b1;
            r1_err_q <= err_q;
          end else begin
            r0_ack_q <= 1'b1;
            r0_err_q <= err_q;
          end
        end
        ACK: begin
          state_q <= IDLE;
          if (id_q) begin
            if (cnt1_q != CNT_MAX) cnt1_q <= cnt1_q + 1'b1;
          end else begin
            if (cnt0_q != CNT_MAX) cnt0_q <= cnt0_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign r0_ack      = r0_ack_q;
  assign r1_ack      = r1_ack_q;
  assign r0_err      = r0_err_q;
  assign r1_err      = r1_err_q;
  assign r0_rdata    = r0_rdata_q;
  assign r1_rdata    = r1_rdata_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_address_q;
  assign mem_data    = mem_data_q;
  assign busy        = (state_q != IDLE);
  assign cnt0        = cnt0_q;
  assign cnt1        = cnt1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed vector table, contention and
// reset-abort sequences, randomized traffic against a transaction-level model,
// and a narrow-counter instance for saturation.
module tb_mem_port_arbiter;

  localparam logic [31:0] BASE  = 32'd1024;
  localparam int          WORDS = 65536;
  localparam logic [31:0] TOP   = BASE + 32'(4 * WORDS);  // first invalid byte

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic        who;
    req_t        q;
    logic        exp_err;
    logic        chk_rdata;
    logic [31:0] exp_rdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_read, r0_write, r1_read, r1_write;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic        r0_ack, r0_err, r1_ack, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_address, mem_data, mem_result;
  logic        busy;
  logic [15:0] cnt0, cnt1;

  // Second instance with a 2-bit counter to reach saturation quickly.
  logic        s_r0_read;
  logic        s_r0_ack, s_r0_err, s_r1_ack, s_r1_err;
  logic [31:0] s_r0_rdata, s_r1_rdata, s_mem_address, s_mem_data;
  logic        s_mem_read, s_mem_write, s_busy;
  logic [1:0]  s_cnt0, s_cnt1;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .r0_read(r0_read), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_err(r0_err), .r0_rdata(r0_rdata),
    .r1_read(r1_read), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_err(r1_err), .r1_rdata(r1_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_data(mem_data), .mem_result(mem_result),
    .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
  );

  mem_port_arbiter #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .r0_read(s_r0_read), .r0_write(1'b0), .r0_addr(BASE), .r0_wdata(32'h0),
    .r0_ack(s_r0_ack), .r0_err(s_r0_err), .r0_rdata(s_r0_rdata),
    .r1_read(1'b0), .r1_write(1'b0), .r1_addr(32'h0), .r1_wdata(32'h0),
    .r1_ack(s_r1_ack), .r1_err(s_r1_err), .r1_rdata(s_r1_rdata),
    .mem_read(s_mem_read), .mem_write(s_mem_write), .mem_address(s_mem_address),
    .mem_data(s_mem_data), .mem_result(32'h0),
    .busy(s_busy), .cnt0(s_cnt0), .cnt1(s_cnt1)
  );

  // ---------------- memory model ----------------
  function automatic logic [31:0] init_word(input int unsigned idx);
    return (32'(idx) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic in_range(input logic [31:0] a);
    return (a >= BASE) && (a < TOP);
  endfunction

  function automatic int unsigned word_idx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  logic [31:0] mem [WORDS];
  logic        mem_loaded = 1'b0;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else if (mem_write && in_range(mem_address)) begin
      mem[word_idx(mem_address)] <= mem_data;
    end
  end

  assign mem_result = (mem_read && in_range(mem_address)) ? mem[word_idx(mem_address)] : 32'h0;

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [int unsigned];
  logic        m_last;
  int          m_cnt [2];
  int          n_checks;
  int          n_pass;

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word((a - BASE) / 4);
  endfunction

  function automatic logic ref_err(input req_t q);
    if (q.rd && q.wr)           return 1'b1;
    if (q.addr % 4 != 0)        return 1'b1;
    if (q.addr < BASE)          return 1'b1;
    if ((q.addr - BASE) / 4 >= 32'(WORDS)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic req_t rand_req();
    req_t        q;
    int unsigned k = $urandom_range(0, 9);
    int unsigned op = $urandom_range(0, 9);
    case (k)
      0:       q.addr = BASE - 32'(4 * $urandom_range(1, 4));
      1:       q.addr = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
      2:       q.addr = TOP + 32'(4 * $urandom_range(0, 3));
      3:       q.addr = TOP - 32'd4;
      default: q.addr = BASE + 32'(4 * $urandom_range(0, 15));
    endcase
    q.rd    = (op == 0) || (op < 5);
    q.wr    = (op == 0) || (op >= 5);
    q.wdata = $urandom;
    return q;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, got, exp);
  endtask

  task automatic drive(input logic v0, input req_t q0, input logic v1, input req_t q1);
    r0_read  = v0 & q0.rd;
    r0_write = v0 & q0.wr;
    r0_addr  = q0.addr;
    r0_wdata = q0.wdata;
    r1_read  = v1 & q1.rd;
    r1_write = v1 & q1.wr;
    r1_addr  = q1.addr;
    r1_wdata = q1.wdata;
  endtask

  // Called at a falling edge with the DUT idle; returns at the falling edge of
  // the idle cycle that follows the ack.
  task automatic run_round(input logic v0, input req_t q0, input logic v1, input req_t q1,
                           output logic win, output logic got_err, output logic [31:0] got_rdata);
    req_t w;
    logic e;
    drive(v0, q0, v1, q1);
    win    = (v0 && v1) ? ~m_last : v1;
    m_last = win;
    w      = win ? q1 : q0;
    e      = ref_err(w);

    @(negedge clk);  // SERVE
    check1("serve_busy", busy, 1'b1);
    check1("serve_mem_write", mem_write, !e && w.wr);
    check1("serve_mem_read", mem_read, !e && w.rd);
    if (!e) check("serve_mem_address", mem_address, w.addr);
    if (!e && w.wr) check("serve_mem_data", mem_data, w.wdata);
    check1("serve_no_ack", r0_ack | r1_ack, 1'b0);

    @(negedge clk);  // ACK
    got_err   = win ? r1_err : r0_err;
    got_rdata = win ? r1_rdata : r0_rdata;
    check1("ack_r0", r0_ack, !win);
    check1("ack_r1", r1_ack, win);
    check1("ack_err", got_err, e);
    if (e || w.rd) check("ack_rdata", got_rdata, e ? 32'h0 : ref_read(w.addr));
    check1("ack_mem_idle", mem_read | mem_write, 1'b0);
    if (!e && w.wr) ref_mem[w.addr] = w.wdata;
    if (m_cnt[win] < 65535) m_cnt[win]++;

    @(negedge clk);  // IDLE again
    check1("idle_busy", busy, 1'b0);
    check("cnt0", 32'(cnt0), 32'(m_cnt[0]));
    check("cnt1", 32'(cnt1), 32'(m_cnt[1]));
  endtask

  task automatic idle_cycles(input int n);
    req_t z;
    z = '{rd: 1'b0, wr: 1'b0, addr: 32'h0, wdata: 32'h0};
    drive(1'b0, z, 1'b0, z);
    repeat (n) begin
      @(negedge clk);
      check1("idle_busy", busy, 1'b0);
      check1("idle_mem_strobes", mem_read | mem_write, 1'b0);
      check1("idle_acks", r0_ack | r1_ack, 1'b0);
    end
  endtask

  function automatic vec_t mk(input logic who, input logic rd, input logic wr,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic exp_err, input logic chk, input logic [31:0] exp_rdata);
    vec_t v;
    v.who = who;
    v.q   = '{rd: rd, wr: wr, addr: addr, wdata: wdata};
    v.exp_err = exp_err;
    v.chk_rdata = chk;
    v.exp_rdata = exp_rdata;
    return v;
  endfunction

  initial begin
    vec_t        tbl [12];
    req_t        z, qa, qb;
    req_t        p [2];
    logic        pv [2];
    logic        win, ge;
    logic [31:0] gr;

    tbl[0]  = mk(0, 0, 1, 32'd1028,          32'h1234_5678, 0, 0, 32'h0);
    tbl[1]  = mk(0, 1, 0, 32'd1028,          32'h0,         0, 1, 32'h1234_5678);
    tbl[2]  = mk(1, 0, 1, 32'd4096,          32'hCAFE_F00D, 0, 0, 32'h0);
    tbl[3]  = mk(1, 1, 0, 32'd4096,          32'h0,         0, 1, 32'hCAFE_F00D);
    tbl[4]  = mk(0, 1, 0, 32'd1020,          32'h0,         1, 1, 32'h0);
    tbl[5]  = mk(1, 1, 0, 32'd1026,          32'h0,         1, 1, 32'h0);
    tbl[6]  = mk(0, 1, 0, 32'd1024 + 262144, 32'h0,         1, 1, 32'h0);
    tbl[7]  = mk(1, 1, 1, 32'd2048,          32'h1111_2222, 1, 1, 32'h0);
    tbl[8]  = mk(0, 0, 1, 32'd1024 + 262140, 32'hFFFF_FFFB, 0, 0, 32'h0);
    tbl[9]  = mk(0, 1, 0, 32'd1024 + 262140, 32'h0,         0, 1, 32'hFFFF_FFFB);
    tbl[10] = mk(0, 1, 0, 32'd1024,          32'h0,         0, 1, 32'h5A5A_0000);
    tbl[11] = mk(1, 0, 1, 32'd1024 + 262141, 32'h0BAD_0BAD, 1, 1, 32'h0);

    z = '{rd: 1'b0, wr: 1'b0, addr: 32'h0, wdata: 32'h0};
    n_checks = 0;
    n_pass   = 0;
    m_last   = 1'b1;
    m_cnt    = '{0, 0};
    s_r0_read = 1'b0;
    drive(1'b0, z, 1'b0, z);
    rst = 1'b1;
    #1 rst = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check1("rst_r0_ack", r0_ack, 1'b0);
    check1("rst_r1_ack", r1_ack, 1'b0);
    check1("rst_errs", r0_err | r1_err, 1'b0);
    check("rst_r0_rdata", r0_rdata, 32'h0);
    check("rst_r1_rdata", r1_rdata, 32'h0);
    check1("rst_mem_strobes", mem_read | mem_write, 1'b0);
    check("rst_mem_address", mem_address, 32'h0);
    check("rst_mem_data", mem_data, 32'h0);
    check1("rst_busy", busy, 1'b0);
    check("rst_cnt0", 32'(cnt0), 32'h0);
    check("rst_cnt1", 32'(cnt1), 32'h0);
    rst = 1'b1;
    idle_cycles(5);

    // Directed vectors, one requester at a time.
    for (int i = 0; i < 12; i++) begin
      run_round(!tbl[i].who, tbl[i].q, tbl[i].who, tbl[i].q, win, ge, gr);
      check1($sformatf("tbl%0d_winner", i), win, tbl[i].who);
      check1($sformatf("tbl%0d_err", i), ge, tbl[i].exp_err);
      if (tbl[i].chk_rdata) check($sformatf("tbl%0d_rdata", i), gr, tbl[i].exp_rdata);
    end

    // Continuous contention: both hold read requests, grants must alternate.
    qa = '{rd: 1'b1, wr: 1'b0, addr: 32'd1028, wdata: 32'h0};
    qb = '{rd: 1'b1, wr: 1'b0, addr: 32'd4096, wdata: 32'h0};
    for (int i = 0; i < 4; i++) run_round(1'b1, qa, 1'b1, qb, win, ge, gr);

    // Randomized traffic; an unserved request stays asserted into the next round.
    pv = '{1'b0, 1'b0};
    for (int r = 0; r < 150; r++) begin
      for (int n = 0; n < 2; n++) begin
        if (!pv[n] && $urandom_range(0, 2) != 0) begin
          p[n]  = rand_req();
          pv[n] = 1'b1;
        end
      end
      if (!pv[0] && !pv[1]) begin
        idle_cycles(1);
      end else begin
        run_round(pv[0], p[0], pv[1], p[1], win, ge, gr);
        pv[win] = 1'b0;
      end
    end
    idle_cycles(2);

    // Reset during SERVE aborts a write and clears everything.
    qa = '{rd: 1'b0, wr: 1'b1, addr: 32'd2048, wdata: 32'hDEAD_BEEF};
    drive(1'b0, z, 1'b1, qa);
    @(negedge clk);
    check1("abort_serve_write", mem_write, 1'b1);
    #1 rst = 1'b0;
    #1;
    check1("abort_mem_write_drop", mem_write, 1'b0);
    check1("abort_busy_drop", busy, 1'b0);
    check("abort_mem_address", mem_address, 32'h0);
    @(negedge clk);
    check1("abort_no_ack", r1_ack, 1'b0);
    check("abort_r1_rdata", r1_rdata, 32'h0);
    check("abort_cnt0", 32'(cnt0), 32'h0);
    check("abort_cnt1", 32'(cnt1), 32'h0);
    drive(1'b0, z, 1'b0, z);
    rst    = 1'b1;
    m_last = 1'b1;
    m_cnt  = '{0, 0};
    qa = '{rd: 1'b1, wr: 1'b0, addr: 32'd2048, wdata: 32'h0};
    run_round(1'b0, z, 1'b1, qa, win, ge, gr);
    check1("abort_readback_not_written", gr == 32'hDEAD_BEEF, 1'b0);
    // Tie right after: requester 0 should win since requester 1 went last.
    qb = '{rd: 1'b1, wr: 1'b0, addr: 32'd1028, wdata: 32'h0};
    run_round(1'b1, qb, 1'b1, qa, win, ge, gr);

    // Counter saturation on the 2-bit instance.
    s_r0_read = 1'b1;
    for (int i = 0; i < 5; i++) begin
      repeat (3) @(negedge clk);
      check($sformatf("sat_cnt0_%0d", i), 32'(s_cnt0), 32'((i + 1 > 3) ? 3 : i + 1));
    end
    s_r0_read = 1'b0;
    check("sat_cnt1", 32'(s_cnt1), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
